// File: rtl/seq_alu_pkg.sv
// Shared constants for seq_alu: op codes, FSM state encoding, flag bit positions.
// The optional divider is enabled by defining SEQ_ALU_DIV_EN.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Combinational single-cycle datapath of seq_alu: add/sub, logic ops, SLT and their flags.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flg
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic           add_v_s;
    logic           sub_v_s;
    logic           slt_s;

    // Shared adder/subtractor; the subtract carry-out is the NOT-borrow.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b};
        diff_s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        sub_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
        slt_s   = diff_s[WIDTH-1] ^ sub_v_s;
    end

    // Result and flag select.
    always_comb begin
        res = {WIDTH{1'b0}};
        flg = 4'b0000;
        case (op)
            OP_ADD: begin
                res = sum_s[WIDTH-1:0];
                flg = pack_flags(res == {WIDTH{1'b0}}, res[WIDTH-1], sum_s[WIDTH], add_v_s);
            end
            OP_SUB: begin
                res = diff_s[WIDTH-1:0];
                flg = pack_flags(res == {WIDTH{1'b0}}, res[WIDTH-1], diff_s[WIDTH], sub_v_s);
            end
            OP_AND: begin
                res = a & b;
                flg = pack_flags(res == {WIDTH{1'b0}}, res[WIDTH-1], 1'b0, 1'b0);
            end
            OP_OR: begin
                res = a | b;
                flg = pack_flags(res == {WIDTH{1'b0}}, res[WIDTH-1], 1'b0, 1'b0);
            end
            OP_SLT: begin
                res = {{(WIDTH-1){1'b0}}, slt_s};
                flg = pack_flags(!slt_s, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                res = {WIDTH{1'b0}};
                flg = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus iterative shift-add MUL and restoring DIVU/REMU.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise ops 110/111 complete at once with V set.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] core_res_s;
    logic [3:0]       core_flg_s;
    logic [WIDTH-1:0] it_acc_s;
    logic [WIDTH-1:0] it_opa_s;
    logic [WIDTH-1:0] it_opb_s;
    logic [WIDTH-1:0] it_res_s;
    logic             last_s;

    seq_alu_core #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .a   (a),
        .b   (b),
        .res (core_res_s),
        .flg (core_flg_s)
    );

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             quo_bit_s;
    logic [WIDTH-1:0] dz_res_s;
`endif

    // One iteration step: opa/opb/acc are multiplicand/multiplier/product for MUL,
    // and quotient-shift/divisor/remainder for DIVU/REMU.
    always_comb begin
        last_s   = (cnt_q == CNT_W'(WIDTH-1));
        it_acc_s = opb_q[0] ? (acc_q + opa_q) : acc_q;
        it_opa_s = {opa_q[WIDTH-2:0], 1'b0};
        it_opb_s = {1'b0, opb_q[WIDTH-1:1]};
        it_res_s = it_acc_s;
`ifdef SEQ_ALU_DIV_EN
        rem_shift_s = {acc_q, opa_q[WIDTH-1]};
        rem_sub_s   = rem_shift_s - {1'b0, opb_q};
        quo_bit_s   = ~rem_sub_s[WIDTH];
        dz_res_s    = (op == OP_DIVU) ? {WIDTH{1'b1}} : a;
        if (op_q != OP_MUL) begin
            it_acc_s = quo_bit_s ? rem_sub_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
            it_opa_s = {opa_q[WIDTH-2:0], quo_bit_s};
            it_opb_s = opb_q;
            it_res_s = (op_q == OP_DIVU) ? it_opa_s : it_acc_s;
        end else begin
            it_res_s = it_acc_s;
        end
`endif
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    opa_d = a;
                    opb_d = b;
                    acc_d = {WIDTH{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                    case (op)
                        OP_MUL: state_d = ST_BUSY;
                        OP_DIVU, OP_REMU: begin
`ifdef SEQ_ALU_DIV_EN
                            if (b == {WIDTH{1'b0}}) begin
                                state_d  = ST_DONE;
                                result_d = dz_res_s;
                                flags_d  = pack_flags(dz_res_s == {WIDTH{1'b0}},
                                                      dz_res_s[WIDTH-1], 1'b0, 1'b1);
                            end else begin
                                state_d = ST_BUSY;
                            end
`else
                            state_d  = ST_DONE;
                            result_d = {WIDTH{1'b0}};
                            flags_d  = pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
`endif
                        end
                        default: begin
                            state_d  = ST_DONE;
                            result_d = core_res_s;
                            flags_d  = core_flg_s;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = it_acc_s;
                opa_d = it_opa_s;
                opb_d = it_opb_s;
                if (last_s) begin
                    state_d  = ST_DONE;
                    result_d = it_res_s;
                    flags_d  = pack_flags(it_res_s == {WIDTH{1'b0}}, it_res_s[WIDTH-1],
                                          1'b0, 1'b0);
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 3'b000;
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
